// File: rtl/i2c_ctrl_pkg.sv
// Shared types and constants for the I2C request arbiter.
package i2c_ctrl_pkg;

  localparam int unsigned I2C_ADDR_W         = 7;
  localparam int unsigned I2C_DATA_W         = 8;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 4096;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_XFER      = 2'd1,
    ST_WAIT_STOP = 2'd2,
    ST_REPORT    = 2'd3
  } arb_state_e;

  // Per-transaction command latched from the winning requester at grant.
  typedef struct packed {
    logic                  rw;
    logic [I2C_ADDR_W-1:0] addr;
  } i2c_cmd_t;

endpackage

// File: rtl/i2c_req_arbiter_if.sv
// Requester and I2C-master signals seen by the arbiter; master = arbiter side.
interface i2c_req_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  import i2c_ctrl_pkg::*;

  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ-1:0]            req_rw;
  logic [I2C_ADDR_W*NUM_REQ-1:0] req_addr;
  logic [I2C_DATA_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ-1:0]            gnt;
  logic [NUM_REQ-1:0]            data_ack;
  logic [NUM_REQ-1:0]            done;
  logic [NUM_REQ-1:0]            err;
  logic                          m_start;
  logic                          m_stop;
  logic                          m_rw;
  logic [I2C_ADDR_W-1:0]         m_addr;
  logic [I2C_DATA_W-1:0]         m_wdata;
  logic                          m_abort;
  logic                          m_busy;
  logic                          m_byte_done;
  logic                          m_nack;

  modport master (
    input  req, req_rw, req_addr, req_data, req_last,
    input  m_busy, m_byte_done, m_nack,
    output gnt, data_ack, done, err,
    output m_start, m_stop, m_rw, m_addr, m_wdata, m_abort
  );

  modport slave (
    output req, req_rw, req_addr, req_data, req_last,
    output m_busy, m_byte_done, m_nack,
    input  gnt, data_ack, done, err,
    input  m_start, m_stop, m_rw, m_addr, m_wdata, m_abort
  );

endinterface

// File: rtl/i2c_req_arbiter_rr.sv
// Round-robin search: first set req bit strictly after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] win,
  output logic [PTR_W-1:0]   win_idx,
  output logic               valid
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    win     = '0;
    win_idx = '0;
    valid   = 1'b0;
    idx     = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = PTR_W'((32'(ptr) + i) % NUM_REQ);
      if (!valid && req[idx]) begin
        valid    = 1'b1;
        win_idx  = idx;
        win[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/i2c_req_arbiter.sv
// Shares one I2C master between NUM_REQ requesters: round-robin grant,
// byte hand-off, stop sequencing, done/err reporting and a progress watchdog.
module i2c_req_arbiter
  import i2c_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int unsigned TMO_W          = $clog2(TIMEOUT_CYCLES)
) (
  input  logic              clk,
  input  logic              reset_n,
  i2c_req_arbiter_if.master bus
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  // Counter value one cycle before it would reach TIMEOUT_CYCLES-1.
  localparam logic [TMO_W-1:0] WDOG_LAST = TMO_W'(TIMEOUT_CYCLES - 2);

  arb_state_e            state;
  logic [PTR_W-1:0]      ptr;
  logic [PTR_W-1:0]      g_idx;
  logic [PTR_W-1:0]      win_idx;
  logic [NUM_REQ-1:0]    win;
  logic                  win_valid;
  logic                  err_flag;
  logic [TMO_W-1:0]      wdog;
  logic                  tmo_hit;
  logic                  cur_last;
  logic [I2C_DATA_W-1:0] cur_data;
  i2c_cmd_t              win_cmd;

  logic [I2C_DATA_W-1:0] data_arr [NUM_REQ];
  logic [I2C_ADDR_W-1:0] addr_arr [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign data_arr[gi] = bus.req_data[gi*I2C_DATA_W +: I2C_DATA_W];
    assign addr_arr[gi] = bus.req_addr[gi*I2C_ADDR_W +: I2C_ADDR_W];
  end

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req     (bus.req),
    .ptr     (ptr),
    .win     (win),
    .win_idx (win_idx),
    .valid   (win_valid)
  );

  // Granted requester's live byte/last flag and the pending winner's command.
  always_comb begin
    cur_last     = bus.req_last[g_idx];
    cur_data     = data_arr[g_idx];
    win_cmd      = '0;
    win_cmd.rw   = bus.req_rw[win_idx];
    win_cmd.addr = addr_arr[win_idx];
  end

  assign tmo_hit     = (wdog >= WDOG_LAST);
  assign bus.m_wdata = (state == ST_XFER) ? cur_data : '0;
  assign bus.m_stop  = (state == ST_XFER) ? cur_last
                                          : (state == ST_WAIT_STOP || state == ST_REPORT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      ptr          <= PTR_W'(NUM_REQ - 1);
      g_idx        <= '0;
      err_flag     <= 1'b0;
      wdog         <= '0;
      bus.gnt      <= '0;
      bus.data_ack <= '0;
      bus.done     <= '0;
      bus.err      <= '0;
      bus.m_start  <= 1'b0;
      bus.m_rw     <= 1'b0;
      bus.m_addr   <= '0;
      bus.m_abort  <= 1'b0;
    end else begin
      bus.data_ack <= '0;
      bus.done     <= '0;
      bus.err      <= '0;
      bus.m_start  <= 1'b0;
      bus.m_abort  <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (win_valid) begin
            bus.gnt     <= win;
            g_idx       <= win_idx;
            bus.m_rw    <= win_cmd.rw;
            bus.m_addr  <= win_cmd.addr;
            bus.m_start <= 1'b1;
            wdog        <= '0;
            err_flag    <= 1'b0;
            state       <= ST_XFER;
          end
        end

        // NACK outranks a coincident byte_done; byte progress outranks timeout.
        ST_XFER: begin
          if (bus.m_nack) begin
            err_flag <= 1'b1;
            wdog     <= wdog + TMO_W'(1);
            state    <= ST_WAIT_STOP;
          end else if (bus.m_byte_done) begin
            bus.data_ack <= bus.gnt;
            wdog         <= '0;
            if (cur_last) begin
              state <= ST_WAIT_STOP;
            end
          end else if (tmo_hit) begin
            bus.m_abort <= 1'b1;
            err_flag    <= 1'b1;
            state       <= ST_REPORT;
          end else begin
            wdog <= wdog + TMO_W'(1);
          end
        end

        ST_WAIT_STOP: begin
          if (!bus.m_busy) begin
            state <= ST_REPORT;
          end else if (tmo_hit) begin
            bus.m_abort <= 1'b1;
            err_flag    <= 1'b1;
            state       <= ST_REPORT;
          end else begin
            wdog <= wdog + TMO_W'(1);
          end
        end

        ST_REPORT: begin
          if (err_flag) begin
            bus.err <= bus.gnt;
          end else begin
            bus.done <= bus.gnt;
          end
          bus.gnt  <= '0;
          ptr      <= g_idx;
          err_flag <= 1'b0;
          state    <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
